// File: rtl/freq_monitor_mc_if.sv
// freq_monitor_mc_if: register-side bundle of the multi-channel frequency monitor.
//   thr_lo/thr_hi  per-channel inclusive limits (master -> monitor)
//   clear_sticky   per-channel sticky-fault clear pulses (master -> monitor)
//   q/q_valid      per-channel window counts and their update strobe (monitor -> master)
//   in_range       per-channel range result, sticky_fault latched faults, window_cnt published windows
interface freq_monitor_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0][CNT_W-1:0] thr_lo, thr_hi, q;
  logic [NUM_CH-1:0]            clear_sticky, in_range, sticky_fault;
  logic                         q_valid;
  logic [15:0]                  window_cnt;
  modport master (output thr_lo, thr_hi, clear_sticky,
                  input  q, q_valid, in_range, sticky_fault, window_cnt);
  modport slave  (input  thr_lo, thr_hi, clear_sticky,
                  output q, q_valid, in_range, sticky_fault, window_cnt);
endinterface

// File: rtl/freq_monitor_mc.sv
// freq_monitor_mc: counts NUM_CH asynchronous clocks per gate window of clk, range-checks and latches faults.
//   clk       reference clock, all outputs in this domain
//   rst_n     synchronous active-low reset
//   clk_meas  clocks under measurement (asynchronous)
//   bus       thresholds/clears in; counts, strobe, range, sticky faults, window count out
module freq_monitor_mc #(
  parameter int NUM_CH      = 4,
  parameter int GATE_CYCLES = 125000000,
  parameter int CNT_W       = 32,
  parameter int PRE_W       = 4,
  parameter int SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] clk_meas,
  freq_monitor_mc_if.slave  bus
);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  if (GATE_CYCLES < 2) begin : g_bad_gate
    $error("GATE_CYCLES must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  typedef enum logic {WARMUP, RUN} state_t;
  state_t state, nxt;
  logic [GW-1:0] gate;
  logic term, publish;
  logic [PRE_W-1:0] gray [NUM_CH];
  logic [PRE_W-1:0] sync [NUM_CH][SYNC_STAGES];
  logic [PRE_W-1:0] bin_now [NUM_CH];
  logic [PRE_W-1:0] bin_prev [NUM_CH];
  logic [CNT_W-1:0] acc [NUM_CH];
  logic [CNT_W-1:0] sum [NUM_CH];
  logic [NUM_CH-1:0] ir_new;
  function automatic logic [PRE_W-1:0] g2b(input logic [PRE_W-1:0] g);
    for (int k = 0; k < PRE_W; k++) g2b[k] = ^(g >> k);
  endfunction
  // Measured domain has no reset; the power-up value 0 is all it needs since only deltas matter.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PRE_W-1:0] cnt = '0;
    logic [PRE_W-1:0] g_r = '0;
    logic [PRE_W-1:0] nx;
    assign nx = cnt + PRE_W'(1);
    assign gray[i] = g_r;
    always_ff @(posedge clk_meas[i]) begin
      cnt <= nx;
      g_r <= nx ^ (nx >> 1);
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      sync[c][0] <= gray[c];
      for (int s = 1; s < SYNC_STAGES; s++) sync[c][s] <= sync[c][s-1];
    end
  end
  // The window result includes the terminal cycle's delta so no edge falls between windows.
  always_comb begin
    logic [PRE_W-1:0] delta;
    logic [CNT_W:0] wide;
    delta = '0;
    wide = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bin_now[c] = g2b(sync[c][SYNC_STAGES-1]);
      delta = bin_now[c] - bin_prev[c];
      wide = {1'b0, acc[c]} + (CNT_W+1)'(delta);
      sum[c] = wide[CNT_W] ? '1 : wide[CNT_W-1:0];
      ir_new[c] = (sum[c] >= bus.thr_lo[c]) && (sum[c] <= bus.thr_hi[c]);
    end
  end
  assign term = gate == GW'(GATE_CYCLES - 1);
  assign publish = term && state == RUN;
  always_comb begin
    nxt = state;
    nxt = term ? RUN : state;
  end
  // A clear landing on an out-of-range result (same edge or during its q_valid cycle) loses to the set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WARMUP;
      gate <= '0;
      bus.q <= '0;
      bus.q_valid <= 1'b0;
      bus.in_range <= '0;
      bus.sticky_fault <= '0;
      bus.window_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        bin_prev[c] <= bin_now[c];
      end
    end else begin
      state <= nxt;
      gate <= term ? '0 : gate + GW'(1);
      bus.q_valid <= publish;
      bus.sticky_fault <= (publish ? ~ir_new : '0) | (bus.q_valid ? ~bus.in_range : '0) |
                          (bus.sticky_fault & ~bus.clear_sticky);
      if (publish) begin
        bus.in_range <= ir_new;
        bus.window_cnt <= bus.window_cnt + 16'd1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        bin_prev[c] <= bin_now[c];
        acc[c] <= term ? '0 : sum[c];
        if (publish) bus.q[c] <= sum[c];
      end
    end
  end
endmodule

// File: tb/tb_freq_monitor_mc.sv
// tb_freq_monitor_mc: directed bench for freq_monitor_mc with four generated measured clocks.
module tb_freq_monitor_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] clk_meas;
  logic cm [4];
  int hnum [4];
  int hden [4];
  int checks = 0;
  int errors = 0;
  freq_monitor_mc_if #(.NUM_CH(4), .CNT_W(32)) bus ();
  freq_monitor_mc #(
    .NUM_CH(4), .GATE_CYCLES(1000), .CNT_W(32), .PRE_W(4), .SYNC_STAGES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_meas(clk_meas), .bus(bus.slave)
  );
  // Reference clock: period 8000 units (8 ns at 1 ps per unit).
  initial forever #4000 clk = ~clk;
  // Each measured clock toggles every hnum/hden units with the remainder carried, so there is no drift.
  for (genvar g = 0; g < 4; g++) begin : g_cm
    assign clk_meas[g] = cm[g];
    initial begin
      longint rem;
      int d;
      rem = 0;
      cm[g] = 1'b0;
      forever begin
        if (hnum[g] == 0) begin
          cm[g] = 1'b0;
          #1000;
        end else begin
          rem += hnum[g];
          d = int'(rem / hden[g]);
          rem -= longint'(d) * hden[g];
          #(d);
          cm[g] = ~cm[g];
        end
      end
    end
  end
  task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
    checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask
  task automatic wait_qv(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.q_valid && n < lim);
    if (!bus.q_valid) check("qv_timeout", longint'(bus.q_valid), 1);
  endtask
  task automatic pulse_clear(input int ch);
    bus.clear_sticky[ch] = 1'b1;
    @(negedge clk);
    bus.clear_sticky[ch] = 1'b0;
  endtask
  initial begin
    int n;
    longint s;
    hnum[0] = 2000; hden[0] = 1;
    hnum[1] = 8000; hden[1] = 1;
    hnum[2] = 0;    hden[2] = 1;
    hnum[3] = 4000; hden[3] = 7;
    bus.thr_lo[0] = 1990; bus.thr_hi[0] = 2010;
    bus.thr_lo[1] = 490;  bus.thr_hi[1] = 510;
    bus.thr_lo[2] = 1;    bus.thr_hi[2] = 10;
    bus.thr_lo[3] = 7100; bus.thr_hi[3] = 6900;
    bus.clear_sticky = '0;
    repeat (5) @(negedge clk);
    for (int c = 0; c < 4; c++) check($sformatf("rst_q%0d", c), bus.q[c], 0);
    check("rst_qv", bus.q_valid, 0);
    check("rst_ir", bus.in_range, 0);
    check("rst_sticky", bus.sticky_fault, 0);
    check("rst_wcnt", bus.window_cnt, 0);
    rst_n = 1'b1;
    wait_qv(2100, n);
    check("first_qv_cycle", n, 2000, 1);
    check("w1_q0", bus.q[0], 2000, 1);
    check("w1_q1", bus.q[1], 500, 1);
    check("w1_q2_stopped", bus.q[2], 0);
    check("w1_q3_7x", bus.q[3], 7000, 1);
    check("w1_ir", bus.in_range, 4'b0011);
    check("w1_sticky", bus.sticky_fault, 4'b1100);
    check("w1_wcnt", bus.window_cnt, 1);
    s = bus.q[0];
    @(negedge clk);
    check("qv_one_cycle", bus.q_valid, 0);
    for (int w = 0; w < 9; w++) begin
      wait_qv(1100, n);
      s += bus.q[0];
    end
    check("sum10_q0", s, 20000, 1);
    check("w10_wcnt", bus.window_cnt, 10);
    repeat (500) @(negedge clk);
    hnum[0] = 2500;
    wait_qv(1100, n);
    wait_qv(1100, n);
    check("slow_q0", bus.q[0], 1600, 1);
    check("slow_ir0", bus.in_range[0], 0);
    check("slow_sticky0", bus.sticky_fault[0], 1);
    repeat (500) @(negedge clk);
    hnum[0] = 2000;
    wait_qv(1100, n);
    wait_qv(1100, n);
    check("back_q0", bus.q[0], 2000, 1);
    check("back_ir0", bus.in_range[0], 1);
    check("back_sticky0", bus.sticky_fault[0], 1);
    repeat (300) @(negedge clk);
    pulse_clear(0);
    check("clear_sticky0", bus.sticky_fault[0], 0);
    hnum[0] = 2500;
    wait_qv(1100, n);
    check("coll_ir0", bus.in_range[0], 0);
    pulse_clear(0);
    check("coll_sticky0", bus.sticky_fault[0], 1);
    hnum[0] = 2000;
    wait_qv(1100, n);
    wait_qv(1100, n);
    check("later_ir0", bus.in_range[0], 1);
    check("later_ir3_inverted", bus.in_range[3], 0);
    check("later_ir2_stopped", bus.in_range[2], 0);
    repeat (100) @(negedge clk);
    pulse_clear(0);
    check("later_clear0", bus.sticky_fault[0], 0);
    repeat (398) @(negedge clk);
    rst_n = 1'b0;
    bus.clear_sticky = 4'b1111;
    @(negedge clk);
    bus.clear_sticky = '0;
    for (int c = 0; c < 4; c++) check($sformatf("mid_rst_q%0d", c), bus.q[c], 0);
    check("mid_rst_qv", bus.q_valid, 0);
    check("mid_rst_ir", bus.in_range, 0);
    check("mid_rst_sticky", bus.sticky_fault, 0);
    check("mid_rst_wcnt", bus.window_cnt, 0);
    rst_n = 1'b1;
    wait_qv(2100, n);
    check("post_rst_qv_cycle", n, 2000, 1);
    check("post_rst_q0", bus.q[0], 2000, 1);
    check("post_rst_wcnt", bus.window_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_monitor_mc.md
Name: freq_monitor_mc

Overview:
- Multi-channel frequency monitor for the clock subsystem. It is the parametrised successor to the single-channel frequency counter.
- Measures NUM_CH asynchronous clocks against the local reference clock over a programmable gate window.
- Each gate window it publishes per-channel counts, range-checks every count against per-channel thresholds, and keeps sticky fault flags for software.
- Feeds the statistics/counter register block and the clock-health status bits.

Parameters:
- NUM_CH, 4, number of measured clock channels (1..16).
- GATE_CYCLES, 125000000, gate window length in clk cycles. At the 125 MHz reference the count reads directly in Hz.
- CNT_W, 32, width of counts and thresholds.
- PRE_W, 4, width of the Gray prescaler in each measured domain. Supports f_meas up to (2^(PRE_W-1)-1) x f_clk.
- SYNC_STAGES, 3, synchroniser depth for the prescaler value (>=2).

Ports:
- clk  in  1  reference clock; all outputs are in this domain.
- rst_n  in  1  synchronous active-low reset.
- clk_meas  in  NUM_CH  clocks under measurement, asynchronous to clk.
- thr_lo  in  NUM_CH x CNT_W  per-channel lower limit, inclusive.
- thr_hi  in  NUM_CH x CNT_W  per-channel upper limit, inclusive.
- clear_sticky  in  NUM_CH  single-cycle pulses; clear the matching sticky_fault bit.
- q  out  NUM_CH x CNT_W  latest per-channel edge count per gate window.
- q_valid  out  1  one-cycle pulse when q updates.
- in_range  out  NUM_CH  per-channel result of thr_lo <= q <= thr_hi for the latest window.
- sticky_fault  out  NUM_CH  set on any out-of-range window; held until cleared.
- window_cnt  out  16  number of completed published windows; wraps at 0xFFFF -> 0.

Behaviour:
- Decided interface rule: one clock (clk); reset rst_n is synchronous and active-low.
- Measured domain:
  - Each channel has a free-running PRE_W-bit Gray counter clocked by clk_meas[i].
  - It has a power-up initial value of 0 and no reset, because rst_n is not available in that domain.
  - Only this Gray value crosses into clk, through SYNC_STAGES flops.
- clk domain, every cycle:
  - Convert the synchronised Gray value to binary.
  - delta = bin_now - bin_prev, modulo 2^PRE_W; then bin_prev <= bin_now.
  - acc <= acc + delta. acc saturates at 2^CNT_W-1 and never wraps.
- Gate counter:
  - Counts 0..GATE_CYCLES-1.
  - On the terminal cycle T, the value acc+delta(T) is the window result. acc restarts at 0, so no edge is lost or double-counted across windows.
- States:
  - WARMUP: entered on reset. The first full window is discarded (q, q_valid, in_range, window_cnt unchanged). This flushes synchroniser and prescaler state. Goes to RUN at the terminal cycle.
  - RUN: at each terminal cycle T, at T+1:
    - q is loaded for all channels.
    - q_valid = 1 for exactly one cycle.
    - in_range is updated from the new q and the thr_lo/thr_hi values sampled at T.
    - window_cnt increments.
- Reset values: q = 0, q_valid = 0, in_range = 0, sticky_fault = 0, window_cnt = 0, gate counter = 0, acc = 0, state = WARMUP.
  - bin_prev loads the synchronised value during reset, so the first post-reset delta is not spurious.
- sticky_fault[i]:
  - Set at T+1 when the new q[i] is out of range.
  - Cleared by clear_sticky[i].
  - If set and clear occur in the same cycle, set wins.
  - clear_sticky is ignored while rst_n = 0.
- Stopped clock: delta = 0, so q = 0. This is a fault whenever thr_lo > 0.
- thr_lo > thr_hi: the channel is always out of range. This is legal and not an error.
- Reset mid-window: partial counts are dropped, state returns to WARMUP, and the outputs take their reset values.
- Accuracy: ±1 count per window from phase and synchroniser quantisation. No accumulated drift across windows.
- Gate counter width is $clog2(GATE_CYCLES). GATE_CYCLES = 1 is illegal; flag it with an elaboration-time assertion.

Test Plan:
- Basic count, two channels:
  - Stimulus: GATE_CYCLES = 1000, clk = 8 ns, clk_meas[0] = 4 ns, clk_meas[1] = 16 ns.
  - Response: first q_valid at ~cycle 2000 (after WARMUP); q[0] = 2000±1, q[1] = 500±1.
  - Over 10 windows the sum of q[0] stays within ±1 of 20000; window_cnt = 10.
- Prescaler limit:
  - Stimulus: PRE_W = 4, clk_meas = 7x clk.
  - Response: q = 7000±1, no aliasing.
- Range check and sticky fault:
  - Stimulus: thr_lo = 1990, thr_hi = 2010 with 4 ns input; then switch input to 5 ns.
  - Response: in_range = 1 and sticky = 0 at first; after the switch the next window gives q = 1600±1, in_range = 0, sticky_fault = 1.
  - Returning to 4 ns: in_range = 1, sticky stays 1 until clear_sticky.
- Set/clear collision:
  - Stimulus: pulse clear_sticky on the same cycle as an out-of-range q_valid.
  - Response: sticky_fault = 1.
  - A clear pulse in a later in-range window gives sticky_fault = 0.
- Stopped clock and inverted thresholds:
  - Stimulus: hold clk_meas[2] = 0; set thr_lo > thr_hi on channel 3.
  - Response: q[2] = 0; in_range[2] = 0 with thr_lo = 1; in_range[3] is always 0.
- Reset mid-window:
  - Stimulus: assert rst_n = 0 at gate cycle 500 of a RUN window.
  - Response: next edge gives q = 0, q_valid = 0, sticky = 0, window_cnt = 0.
  - No q_valid occurs until one full WARMUP window plus one RUN window (2000 cycles) after release.
